// File: rtl/pc_seq_pkg.sv
// Shared constants for the PC-source sequencer: instruction fields, PC mux
// selector encodings and controller states.
package pc_seq_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_RTE  = 6'h13;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [2:0] SEL_PC4  = 3'b000;
  localparam logic [2:0] SEL_ALU  = 3'b001;
  localparam logic [2:0] SEL_JUMP = 3'b010;
  localparam logic [2:0] SEL_EPC  = 3'b011;
  localparam logic [2:0] SEL_IMM  = 3'b100;
  localparam logic [2:0] SEL_MEM  = 3'b101;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_BRANCH   = 4'd3,
    S_JUMP     = 4'd4,
    S_RTE      = 4'd5,
    S_EXC_SAVE = 4'd6,
    S_EXC_RD   = 4'd7,
    S_EXC_LOAD = 4'd8,
    S_DONE     = 4'd9
  } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/handshake bundle between the datapath and the PC-source sequencer.
interface pc_sequencer_if;
  logic       start;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       mem_ready;
  logic [2:0] pc_src_sel;
  logic       pc_write;
  logic       epc_write;
  logic       mem_req;
  logic [7:0] vec_addr;
  logic       busy;
  logic       done;

  modport master (
    output start, opcode, funct, zero, overflow, mem_ready,
    input  pc_src_sel, pc_write, epc_write, mem_req, vec_addr, busy, done
  );

  modport slave (
    input  start, opcode, funct, zero, overflow, mem_ready,
    output pc_src_sel, pc_write, epc_write, mem_req, vec_addr, busy, done
  );
endinterface

// File: rtl/pc_seq_decode.sv
// Combinational instruction classifier; outputs are already prioritised so at
// most one of them is asserted.
module pc_seq_decode
  import pc_seq_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       exc_opcode,
  output logic       exc_ovfl,
  output logic       branch_taken,
  output logic       jump,
  output logic       rte
);

  logic op_ok;
  logic fn_ok;
  logic ovfl_insn;
  logic no_exc;

  always_comb begin
    op_ok = opcode inside {OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
                           OP_ADDI, OP_ADDIU, OP_LUI, OP_LW, OP_SW};
    fn_ok = funct inside {FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                          FN_SLT, FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_RTE};
    ovfl_insn = ((opcode == OP_RTYPE) && ((funct == FN_ADD) || (funct == FN_SUB)))
              || (opcode == OP_ADDI);

    exc_opcode   = !op_ok || ((opcode == OP_RTYPE) && !fn_ok);
    exc_ovfl     = !exc_opcode && overflow && ovfl_insn;
    no_exc       = !exc_opcode && !exc_ovfl;
    branch_taken = no_exc && (((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero));
    jump         = no_exc && ((opcode == OP_J) || (opcode == OP_JAL));
    rte          = no_exc && (opcode == OP_RTYPE) && (funct == FN_RTE);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle PC-source sequencer: fetch, branch, jump, rte and exception
// vector load, one instruction per start pulse. All outputs decode registered state.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [7:0] VEC_OPCODE = 8'd253,
  parameter logic [7:0] VEC_OVFL   = 8'd254
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  state_e     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic [5:0] funct_q, funct_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] vec_q, vec_d;

  logic exc_opcode, exc_ovfl, branch_taken, jump, rte;

  pc_seq_decode u_decode (
    .opcode       (opcode_q),
    .funct        (funct_q),
    .zero         (bus.zero),
    .overflow     (bus.overflow),
    .exc_opcode   (exc_opcode),
    .exc_ovfl     (exc_ovfl),
    .branch_taken (branch_taken),
    .jump         (jump),
    .rte          (rte)
  );

  // Selector is registered alongside the state it belongs to, so it only
  // changes when a PC-writing state is entered and holds otherwise.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    funct_d  = funct_q;
    sel_d    = sel_q;
    vec_d    = vec_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          opcode_d = bus.opcode;
          funct_d  = bus.funct;
          sel_d    = SEL_PC4;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (exc_opcode) begin
          vec_d   = VEC_OPCODE;
          state_d = S_EXC_SAVE;
        end else if (exc_ovfl) begin
          vec_d   = VEC_OVFL;
          state_d = S_EXC_SAVE;
        end else if (branch_taken) begin
          sel_d   = SEL_ALU;
          state_d = S_BRANCH;
        end else if (jump) begin
          sel_d   = SEL_JUMP;
          state_d = S_JUMP;
        end else if (rte) begin
          sel_d   = SEL_EPC;
          state_d = S_RTE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_BRANCH, S_JUMP, S_RTE, S_EXC_LOAD: state_d = S_DONE;
      S_EXC_SAVE: state_d = S_EXC_RD;
      S_EXC_RD: begin
        if (bus.mem_ready) begin
          sel_d   = SEL_MEM;
          state_d = S_EXC_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      funct_q  <= '0;
      sel_q    <= SEL_PC4;
      vec_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
      sel_q    <= sel_d;
      vec_q    <= vec_d;
    end
  end

  assign bus.pc_src_sel = sel_q;
  assign bus.vec_addr   = vec_q;
  assign bus.pc_write   = (state_q == S_FETCH) || (state_q == S_BRANCH) || (state_q == S_JUMP)
                        || (state_q == S_RTE) || (state_q == S_EXC_LOAD);
  assign bus.epc_write  = (state_q == S_EXC_SAVE);
  assign bus.mem_req    = (state_q == S_EXC_RD);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected output events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer #(.VEC_OPCODE(8'd253), .VEC_OVFL(8'd254)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit       pw, ew, mr, dn;
    bit [2:0] sel;
    bit [7:0] vec;
    int       t;
  } ev_t;

  localparam bit [5:0] VALID_OPS [10] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                                          6'h08, 6'h09, 6'h0F, 6'h23, 6'h2B};
  localparam bit [5:0] VALID_FNS [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                          6'h2A, 6'h00, 6'h02, 6'h03, 6'h08, 6'h13};
  localparam int K_NONE = 0, K_BRANCH = 1, K_JUMP = 2, K_RTE = 3, K_EXC_OP = 4, K_EXC_OV = 5;

  ev_t         exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          cyc      = 0;
  int          start_n  = 0;
  bit          mr_prev  = 1'b0;
  bit          sel_chk_en = 1'b0;
  bit [2:0]    last_sel = 3'b000;
  ev_t         act_ev, exp_ev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference classification taken straight from the decode rules.
  function automatic int classify(bit [5:0] op, bit [5:0] fn, bit z, bit ov);
    bit op_ok = 1'b0;
    bit fn_ok = 1'b0;
    foreach (VALID_OPS[i]) if (VALID_OPS[i] == op) op_ok = 1'b1;
    foreach (VALID_FNS[i]) if (VALID_FNS[i] == fn) fn_ok = 1'b1;
    if (!op_ok || (op == 6'h00 && !fn_ok)) return K_EXC_OP;
    if (ov && ((op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) || op == 6'h08)) return K_EXC_OV;
    if ((op == 6'h04 && z) || (op == 6'h05 && !z)) return K_BRANCH;
    if (op == 6'h02 || op == 6'h03) return K_JUMP;
    if (op == 6'h00 && fn == 6'h13) return K_RTE;
    return K_NONE;
  endfunction

  function automatic ev_t mk(bit pw, bit ew, bit mr, bit dn, bit [2:0] sel, bit [7:0] vec, int t);
    ev_t e;
    e.pw = pw; e.ew = ew; e.mr = mr; e.dn = dn; e.sel = sel; e.vec = vec; e.t = t;
    return e;
  endfunction

  // Monitor: an event is any PC/EPC write, done, or the rising edge of mem_req.
  always @(negedge clk) begin
    if (!reset && (bus.pc_write || bus.epc_write || bus.done || (bus.mem_req && !mr_prev))) begin
      act_ev = mk(bus.pc_write, bus.epc_write, bus.mem_req && !mr_prev, bus.done,
                  bus.pc_src_sel, bus.vec_addr, cyc - start_n + 1);
      if (exp_q.size() == 0) begin
        check("spurious_event", {act_ev.pw, act_ev.ew, act_ev.mr, act_ev.dn}, 4'b0000);
      end else begin
        exp_ev = exp_q.pop_front();
        check("ev_flags", {act_ev.pw, act_ev.ew, act_ev.mr, act_ev.dn},
                          {exp_ev.pw, exp_ev.ew, exp_ev.mr, exp_ev.dn});
        check("ev_cycle", act_ev.t, exp_ev.t);
        if (exp_ev.pw) begin
          check("ev_sel", act_ev.sel, exp_ev.sel);
          last_sel = exp_ev.sel;
        end
        if (exp_ev.mr) check("ev_vec_addr", act_ev.vec, exp_ev.vec);
      end
    end
    if (!reset && sel_chk_en && !bus.pc_write) check("sel_hold", bus.pc_src_sel, last_sel);
    mr_prev = bus.mem_req;
  end

  // Cycle 0 drives start; cycle t (t>=1) is the t-th state after acceptance.
  task automatic run_insn(input bit [5:0] op, input bit [5:0] fn, input bit z, input bit ov,
                          input int w, input int reset_at);
    int kind, done_t;
    bit [7:0] vec;
    @(posedge clk); #1;
    check("idle_before_start", {bus.busy, bus.done}, 2'b00);
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.funct  = fn;
    start_n    = cyc + 1;
    kind = classify(op, fn, z, ov);
    exp_q.push_back(mk(1, 0, 0, 0, 3'b000, 8'd0, 1));
    case (kind)
      K_EXC_OP, K_EXC_OV: begin
        vec = (kind == K_EXC_OP) ? 8'd253 : 8'd254;
        exp_q.push_back(mk(0, 1, 0, 0, 3'b000, 8'd0, 3));
        exp_q.push_back(mk(0, 0, 1, 0, 3'b000, vec, 4));
        exp_q.push_back(mk(1, 0, 0, 0, 3'b101, 8'd0, 5 + w));
        exp_q.push_back(mk(0, 0, 0, 1, 3'b000, 8'd0, 6 + w));
        done_t = 6 + w;
      end
      K_BRANCH, K_JUMP, K_RTE: begin
        exp_q.push_back(mk(1, 0, 0, 0, 3'(kind), 8'd0, 3));
        exp_q.push_back(mk(0, 0, 0, 1, 3'b000, 8'd0, 4));
        done_t = 4;
      end
      default: begin
        exp_q.push_back(mk(0, 0, 0, 1, 3'b000, 8'd0, 3));
        done_t = 3;
      end
    endcase
    for (int t = 1; t <= done_t; t++) begin
      @(posedge clk); #1;
      if (reset_at != 0 && t == reset_at + 1) begin
        reset = 1'b0;
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_writes", {bus.pc_write, bus.epc_write, bus.done}, 3'b000);
        check("rst_sel", bus.pc_src_sel, 3'b000);
        check("rst_vec_addr", bus.vec_addr, 8'd0);
        bus.start = 1'b0;
        return;
      end
      bus.start     = ($urandom_range(0, 2) == 0);
      bus.zero      = (t == 2) ? z  : 1'($urandom);
      bus.overflow  = (t == 2) ? ov : 1'($urandom);
      if (t >= 4 && t < 4 + w && (kind == K_EXC_OP || kind == K_EXC_OV)) bus.mem_ready = 1'b0;
      else if (t == 4 + w && (kind == K_EXC_OP || kind == K_EXC_OV)) bus.mem_ready = 1'b1;
      else bus.mem_ready = 1'($urandom);
      if (reset_at != 0 && t == reset_at) begin
        reset = 1'b1;
        exp_q.delete();
        last_sel = 3'b000;
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit [5:0] op, fn;
    reset = 1'b1;
    bus.start = 1'b0; bus.opcode = '0; bus.funct = '0;
    bus.zero = 1'b0; bus.overflow = 1'b0; bus.mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_outs", {bus.pc_write, bus.epc_write, bus.mem_req, bus.busy, bus.done}, 5'b0);
    check("reset_sel", bus.pc_src_sel, 3'b000);
    check("reset_vec", bus.vec_addr, 8'd0);
    sel_chk_en = 1'b1;

    run_insn(6'h00, 6'h21, 1'b0, 1'b0, 0, 0);   // addu
    run_insn(6'h04, 6'h00, 1'b1, 1'b0, 0, 0);   // beq taken
    run_insn(6'h04, 6'h00, 1'b0, 1'b0, 0, 0);   // beq not taken
    run_insn(6'h05, 6'h00, 1'b0, 1'b0, 0, 0);   // bne taken
    run_insn(6'h02, 6'h00, 1'b0, 1'b0, 0, 0);   // j
    run_insn(6'h00, 6'h13, 1'b0, 1'b0, 0, 0);   // rte
    run_insn(6'h3F, 6'h00, 1'b0, 1'b0, 3, 0);   // invalid opcode, slow memory
    run_insn(6'h00, 6'h20, 1'b0, 1'b1, 0, 0);   // add overflow, fastest vector load
    run_insn(6'h3F, 6'h20, 1'b0, 1'b1, 1, 0);   // invalid beats overflow
    run_insn(6'h08, 6'h00, 1'b0, 1'b1, 2, 0);   // addi overflow
    run_insn(6'h00, 6'h3F, 1'b0, 1'b0, 0, 0);   // unsupported funct
    run_insn(6'h3F, 6'h00, 1'b0, 1'b0, 3, 5);   // reset during EXC_RD
    run_insn(6'h00, 6'h21, 1'b0, 1'b0, 0, 0);   // recovery after reset

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      else op = VALID_OPS[$urandom_range(0, 9)];
      if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
      else fn = VALID_FNS[$urandom_range(0, 11)];
      run_insn(op, fn, 1'($urandom), 1'($urandom), $urandom_range(0, 4), 0);
    end

    repeat (3) @(posedge clk);
    #1 check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multicycle controller that sequences the PC-source selection path of the datapath. It drives the 3-bit PC-source selector, `pc_write` and `epc_write` through fetch, branch, jump, return-from-exception and exception-vector-load sequences. One instruction is handled per `start` pulse. Its outputs feed the PC-source mux, the PC and EPC registers, and the memory request used for exception vector fetch.

## Interface
- `VEC_OPCODE`, default 8'd253: memory byte address of the handler vector for an invalid opcode.
- `VEC_OVFL`, default 8'd254: memory byte address of the handler vector for arithmetic overflow.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin sequencing; only sampled in IDLE.
- `opcode` in 6: instruction [31:26]; sampled with `start`.
- `funct` in 6: instruction [5:0]; sampled with `start`.
- `zero` in 1: ALU zero flag; sampled in DECODE.
- `overflow` in 1: ALU overflow flag; sampled in DECODE.
- `mem_ready` in 1: memory read-data valid for the vector fetch.
- `pc_src_sel` out 3: PC-source mux selector.
- `pc_write` out 1: PC load enable.
- `epc_write` out 1: EPC load enable.
- `mem_req` out 1: vector read request.
- `vec_addr` out 8: vector address, valid while `mem_req` is high.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- **Selector encoding:** 000 PC+4, 001 ALUOut (branch target), 010 jump target, 011 EPC, 100 sign-extended immediate (reserved, never driven), 101 memory read data.
- **Output style:** all outputs are Moore outputs decoded from the registered state. `opcode` and `funct` are latched on `start`.
- **Reset:** state IDLE. `pc_src_sel`=000, `vec_addr`=0. All 1-bit outputs are 0.
- **States and transitions:**
  - IDLE: `start` -> FETCH.
  - FETCH: `pc_write`=1, sel 000. Always -> DECODE.
  - DECODE: classify the latched instruction; rules below, first match wins.
    1. Opcode not in {00,02,03,04,05,08,09,0F,23,2B}, or opcode 00 with an unsupported funct -> EXC_SAVE, vector VEC_OPCODE.
    2. `overflow`=1 and the instruction is add (00/20), sub (00/22) or addi (08) -> EXC_SAVE, vector VEC_OVFL.
    3. beq (04) with `zero`=1, or bne (05) with `zero`=0 -> BRANCH.
    4. j (02) or jal (03) -> JUMP.
    5. rte (00/13) -> RTE.
    6. Otherwise -> DONE.
  - BRANCH: `pc_write`=1, sel 001. -> DONE.
  - JUMP: `pc_write`=1, sel 010. -> DONE.
  - RTE: `pc_write`=1, sel 011. -> DONE.
  - EXC_SAVE: `epc_write`=1. -> EXC_RD.
  - EXC_RD: `mem_req`=1, `vec_addr` = latched vector. Stays until `mem_ready`=1, then -> EXC_LOAD.
  - EXC_LOAD: `pc_write`=1, sel 101. -> DONE.
  - DONE: `done`=1. -> IDLE.
- Supported funct values for opcode 00: 20, 21, 22, 23, 24, 25, 2A, 00, 02, 03, 08, 13.
- Invalid opcode has priority over overflow when both apply.
- `start` outside IDLE is ignored. `mem_ready` outside EXC_RD is ignored.
- `pc_src_sel` holds its last value when `pc_write`=0.

## Timing
- `start` high at edge n. Then:
  - n+1 FETCH
  - n+2 DECODE
  - n+3 action state, or DONE for a not-taken / no-PC-change instruction
  - n+4 DONE (taken branch, jump, rte)
- Exception path: EXC_SAVE n+3, EXC_RD from n+4. If `mem_ready` is seen at edge m, EXC_LOAD is at m+1 and DONE at m+2. With `mem_ready` already high on the first EXC_RD cycle, the minimum is DONE at n+6.
- `start` high during DONE is ignored. A new `start` is accepted in IDLE, one cycle after DONE at the earliest.
- `reset` in any state: IDLE with reset outputs on the next edge. An in-flight `mem_req` drops, and no PC or EPC write occurs on that edge.
- No combinational path exists from any input to any output.

## Structure
- Package `pc_seq_pkg` holds:
  - opcode and funct localparams
  - selector encodings (`SEL_PC4` … `SEL_MEM`)
  - state enum
- Sub-module `pc_seq_decode`: combinational classifier from (`opcode`, `funct`, `zero`, `overflow`) to {exc_opcode, exc_ovfl, branch_taken, jump, rte}. The FSM stays in `pc_sequencer`.

## Test plan
- **Reset and fetch:** `reset`, then `start` with addu (00/21). Expect `pc_write` at n+1 with sel 000, `done` at n+3, no other writes.
- **beq:** opcode 04 with `zero`=1 -> `pc_write` with sel 001 at n+3, `done` n+4. Repeat with `zero`=0 -> `done` n+3, single `pc_write`.
- **j and rte:** j (02) -> sel 010 at n+3. rte (00/13) -> sel 011 at n+3.
- **Invalid opcode:** opcode 3F -> `epc_write` n+3; `mem_req` with `vec_addr`=253 from n+4. Hold `mem_ready` low 3 cycles, then high -> sel 101 with `pc_write` the next cycle, then `done`.
- **Overflow and priority:** add with `overflow`=1 -> `vec_addr`=254. Opcode 3F with `overflow`=1 -> 253.
- **Reset mid-operation:** assert `reset` during EXC_RD -> next cycle IDLE, `mem_req`=0, `busy`=0. A `start` pulse while `busy` is high is ignored.
